i2c_slave: RTL and testbench

//   I2C target (slave) for the far end of the bus driven by our I2C master.

---
 rtl/i2c_slave.sv | 170 +++++++++++++++++
 tb/tb_i2c_slave.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave.sv
// i2c_slave: I2C target with a fixed 7-bit address that receives write bytes and transmits read bytes
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_load,
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK} state_t;
  state_t     state_q, state_d;
  logic [2:0] scl_q, sda_q;
  logic [2:0] cnt_q, cnt_d;
  logic       full_q, full_d;
  logic [7:0] shreg_q, shreg_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_load_q, tx_load_d;
  logic       busy_q, busy_d;
  logic       scl_r, scl_f, start_ev, stop_ev;
  logic [7:0] byte_in;
  // two-flop synchronisers plus one delay flop per line; idle bus level is high
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], scl_in};
      sda_q <= {sda_q[1:0], sda_in};
    end
  end
  assign scl_r    = scl_q[1] & ~scl_q[2];
  assign scl_f    = ~scl_q[1] & scl_q[2];
  assign start_ev = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
  assign stop_ev  = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];
  assign byte_in  = {shreg_q[6:0], sda_q[1]};
  // protocol state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      full_q     <= 1'b0;
      shreg_q    <= '0;
      sda_oe_q   <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_load_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      full_q     <= full_d;
      shreg_q    <= shreg_d;
      sda_oe_q   <= sda_oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_load_q  <= tx_load_d;
      busy_q     <= busy_d;
    end
  end
  // next-state: START/STOP override bit handling; bits sampled on SCL rise, SDA driven on SCL fall
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    full_d     = full_q;
    shreg_d    = shreg_q;
    sda_oe_d   = sda_oe_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_load_d  = 1'b0;
    busy_d     = busy_q;
    if (start_ev) begin
      state_d  = ADDR;
      cnt_d    = '0;
      full_d   = 1'b0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b1;
    end else if (stop_ev) begin
      state_d  = IDLE;
      cnt_d    = '0;
      full_d   = 1'b0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_r && !full_q) begin
            shreg_d = byte_in;
            cnt_d   = cnt_q + 3'd1;
            full_d  = &cnt_q;
          end else if (scl_f && full_q) begin
            full_d = 1'b0;
            if (shreg_q[7:1] == SLAVE_ADDR) begin
              sda_oe_d = 1'b1;
              state_d  = ADDR_ACK;
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_f && shreg_q[0]) begin
            tx_load_d = 1'b1;
            shreg_d   = tx_data;
            sda_oe_d  = ~tx_data[7];
            cnt_d     = '0;
            state_d   = TX;
          end else if (scl_f) begin
            sda_oe_d = 1'b0;
            state_d  = RX;
          end
        end
        RX: begin
          if (scl_r && !full_q) begin
            shreg_d    = byte_in;
            cnt_d      = cnt_q + 3'd1;
            full_d     = &cnt_q;
            rx_valid_d = &cnt_q;
            rx_data_d  = &cnt_q ? byte_in : rx_data_q;
          end else if (scl_f && full_q) begin
            full_d   = 1'b0;
            sda_oe_d = 1'b1;
            state_d  = RX_ACK;
          end
        end
        RX_ACK: begin
          if (scl_f) begin
            sda_oe_d = 1'b0;
            state_d  = RX;
          end
        end
        TX: begin
          if (scl_f && &cnt_q) begin
            sda_oe_d = 1'b0;
            cnt_d    = '0;
            state_d  = TX_ACK;
          end else if (scl_f) begin
            shreg_d  = {shreg_q[6:0], 1'b0};
            sda_oe_d = ~shreg_q[6];
            cnt_d    = cnt_q + 3'd1;
          end
        end
        TX_ACK: begin
          if (scl_r && sda_q[1]) begin
            state_d = IDLE;
          end else if (scl_f) begin
            tx_load_d = 1'b1;
            shreg_d   = tx_data;
            sda_oe_d  = ~tx_data[7];
            state_d   = TX;
          end
        end
        default: ;
      endcase
    end
  end
  assign sda_oe   = sda_oe_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_load  = tx_load_q;
  assign busy     = busy_q;
endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: directed bus-master bench for i2c_slave with an open-drain SDA model
module tb_i2c_slave;
  localparam int Q = 5;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       sda_in, sda_oe, rx_valid, tx_load, busy;
  logic [7:0] rx_data;
  int checks = 0;
  int errors = 0;
  int rxv_n = 0;
  int txl_n = 0;
  int oe_n = 0;
  int both_n = 0;
  assign sda_in = sda_m & ~sda_oe;
  always #5 clk = ~clk;
  i2c_slave dut (
    .clk(clk), .rst(rst), .scl_in(scl_m), .sda_in(sda_in), .sda_oe(sda_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_load(tx_load), .busy(busy)
  );
  // cycle counters for pulse outputs, sampled away from the active edge
  always @(negedge clk) begin
    if (rx_valid) rxv_n <= rxv_n + 1;
    if (tx_load) txl_n <= txl_n + 1;
    if (sda_oe) oe_n <= oe_n + 1;
    if (rx_valid && tx_load) both_n <= both_n + 1;
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic clk_bit(input logic b, output logic r, output logic o);
    sda_m = b;
    tick(Q);
    scl_m = 1'b1;
    tick(Q);
    r = sda_in;
    o = sda_oe;
    tick(Q);
    scl_m = 1'b0;
    tick(Q);
  endtask
  task automatic do_start;
    sda_m = 1'b1;
    tick(Q);
    scl_m = 1'b1;
    tick(Q);
    sda_m = 1'b0;
    tick(Q);
    scl_m = 1'b0;
    tick(Q);
  endtask
  task automatic do_stop;
    sda_m = 1'b0;
    tick(Q);
    scl_m = 1'b1;
    tick(Q);
    sda_m = 1'b1;
    tick(Q);
  endtask
  task automatic write_byte(input logic [7:0] d, output logic ack, output logic oe);
    logic r, o;
    for (int i = 7; i >= 0; i--) clk_bit(d[i], r, o);
    clk_bit(1'b1, r, oe);
    ack = ~r;
  endtask
  task automatic read_byte(input logic m_ack, output logic [7:0] d);
    logic r, o;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, r, o);
      d[i] = r;
    end
    clk_bit(~m_ack, r, o);
  endtask
  task automatic test_reset;
    rst = 1'b1;
    tick(3);
    checks++;
    if ({sda_oe, rx_valid, tx_load, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: got oe,rxv,txl,busy=%b want 0000", {sda_oe, rx_valid, tx_load, busy});
    end
    checks++;
    if (rx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_rx_data: got %h want 00", rx_data);
    end
    rst = 1'b0;
    tick(3);
  endtask
  task automatic test_write;
    logic ack, oe;
    int rv0;
    rv0 = rxv_n;
    do_start;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL write_busy: got %b want 1", busy);
    end
    write_byte(8'hA0, ack, oe);
    checks++;
    if ({ack, oe} !== 2'b11) begin
      errors++;
      $display("FAIL write_addr_ack: got ack,oe=%b want 11", {ack, oe});
    end
    write_byte(8'hA5, ack, oe);
    checks++;
    if ({ack, oe} !== 2'b11) begin
      errors++;
      $display("FAIL write_data_ack: got ack,oe=%b want 11", {ack, oe});
    end
    checks++;
    if (rx_data !== 8'hA5) begin
      errors++;
      $display("FAIL write_rx_data: got %h want a5", rx_data);
    end
    checks++;
    if (rxv_n - rv0 != 1) begin
      errors++;
      $display("FAIL write_rx_valid_cycles: got %0d want 1", rxv_n - rv0);
    end
    do_stop;
    tick(Q);
    checks++;
    if ({busy, sda_oe} !== 2'b00) begin
      errors++;
      $display("FAIL write_after_stop: got busy,oe=%b want 00", {busy, sda_oe});
    end
  endtask
  task automatic test_bad_addr;
    logic ack, oe;
    int rv0, oe0;
    rv0 = rxv_n;
    oe0 = oe_n;
    do_start;
    write_byte(8'hA2, ack, oe);
    checks++;
    if (ack !== 1'b0) begin
      errors++;
      $display("FAIL bad_addr_ack: got %b want 0", ack);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL bad_addr_busy: got %b want 0", busy);
    end
    write_byte(8'hA5, ack, oe);
    do_stop;
    checks++;
    if (oe_n != oe0) begin
      errors++;
      $display("FAIL bad_addr_oe_cycles: got %0d want 0", oe_n - oe0);
    end
    checks++;
    if (rxv_n != rv0) begin
      errors++;
      $display("FAIL bad_addr_rx_valid: got %0d want 0", rxv_n - rv0);
    end
  endtask
  task automatic test_read;
    logic ack, oe;
    logic [7:0] d;
    int tl0;
    tl0 = txl_n;
    tx_data = 8'h3C;
    do_start;
    write_byte(8'hA1, ack, oe);
    checks++;
    if ({ack, oe} !== 2'b11) begin
      errors++;
      $display("FAIL read_addr_ack: got ack,oe=%b want 11", {ack, oe});
    end
    tx_data = 8'hC3;
    read_byte(1'b1, d);
    checks++;
    if (d !== 8'h3C) begin
      errors++;
      $display("FAIL read_byte0: got %h want 3c", d);
    end
    read_byte(1'b0, d);
    checks++;
    if (d !== 8'hC3) begin
      errors++;
      $display("FAIL read_byte1: got %h want c3", d);
    end
    checks++;
    if (txl_n - tl0 != 2) begin
      errors++;
      $display("FAIL read_tx_load_cycles: got %0d want 2", txl_n - tl0);
    end
    checks++;
    if (sda_oe !== 1'b0) begin
      errors++;
      $display("FAIL read_oe_after_nack: got %b want 0", sda_oe);
    end
    do_stop;
    tick(Q);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL read_busy_after_stop: got %b want 0", busy);
    end
  endtask
  task automatic test_back_to_back;
    logic ack, oe, r, o;
    logic [7:0] d;
    int rv0;
    rv0 = rxv_n;
    do_start;
    write_byte(8'hA0, ack, oe);
    write_byte(8'hA5, ack, oe);
    for (int i = 0; i < 4; i++) clk_bit(1'b0, r, o);
    tx_data = 8'h5A;
    do_start;
    write_byte(8'hA1, ack, oe);
    checks++;
    if ({ack, oe} !== 2'b11) begin
      errors++;
      $display("FAIL rstart_addr_ack: got ack,oe=%b want 11", {ack, oe});
    end
    tx_data = 8'h00;
    read_byte(1'b0, d);
    checks++;
    if (d !== 8'h5A) begin
      errors++;
      $display("FAIL rstart_read: got %h want 5a", d);
    end
    do_stop;
    checks++;
    if (rxv_n - rv0 != 1) begin
      errors++;
      $display("FAIL rstart_rx_valid_cycles: got %0d want 1", rxv_n - rv0);
    end
    checks++;
    if (rx_data !== 8'hA5) begin
      errors++;
      $display("FAIL rstart_rx_data: got %h want a5", rx_data);
    end
  endtask
  task automatic test_stop_partial;
    logic ack, oe, r, o;
    int rv0;
    rv0 = rxv_n;
    do_start;
    write_byte(8'hA0, ack, oe);
    for (int i = 0; i < 4; i++) clk_bit(1'b1, r, o);
    do_stop;
    tick(Q);
    checks++;
    if (rxv_n != rv0) begin
      errors++;
      $display("FAIL partial_rx_valid: got %0d want 0", rxv_n - rv0);
    end
    checks++;
    if ({busy, sda_oe} !== 2'b00) begin
      errors++;
      $display("FAIL partial_idle: got busy,oe=%b want 00", {busy, sda_oe});
    end
  endtask
  task automatic test_reset_mid;
    logic ack, oe;
    tx_data = 8'h00;
    do_start;
    write_byte(8'hA1, ack, oe);
    checks++;
    if (sda_oe !== 1'b1) begin
      errors++;
      $display("FAIL midrst_tx_driving: got %b want 1", sda_oe);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({sda_oe, busy} !== 2'b00) begin
      errors++;
      $display("FAIL midrst_release: got oe,busy=%b want 00", {sda_oe, busy});
    end
    tick(1);
    rst = 1'b0;
    tick(3);
    do_start;
    write_byte(8'hA0, ack, oe);
    checks++;
    if ({ack, oe} !== 2'b11) begin
      errors++;
      $display("FAIL midrst_next_ack: got ack,oe=%b want 11", {ack, oe});
    end
    do_stop;
    tick(Q);
  endtask
  initial begin
    test_reset;
    test_write;
    test_bad_addr;
    test_read;
    test_back_to_back;
    test_stop_partial;
    test_reset_mid;
    checks++;
    if (both_n != 0) begin
      errors++;
      $display("FAIL rxv_txl_overlap: got %0d cycles want 0", both_n);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
